// File: rtl/guess_engine.sv
// guess_engine: bulls-and-cows core with serial scoring, attempt count and guess history.
// Define GUESS_HIST_SCORE_EN to also store per-guess scores, read back on rd_a/rd_b.
module guess_engine #(
   parameter int DIGITS    = 4,
   parameter int MAX_TRIES = 8,
   parameter int AW        = 3,
   localparam int CW = $clog2(DIGITS + 1),
   localparam int GW = 4 * DIGITS
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [GW-1:0] secret,
   input  logic          submit,
   input  logic [GW-1:0] guess,
   output logic          busy,
   output logic          result_valid,
   output logic          err,
   output logic [CW-1:0] a_cnt,
   output logic [CW-1:0] b_cnt,
   output logic [AW:0]   tries,
   output logic [1:0]    state,
   input  logic [AW-1:0] rd_addr,
`ifdef GUESS_HIST_SCORE_EN
   output logic [GW-1:0] rd_guess,
   output logic [CW-1:0] rd_a,
   output logic [CW-1:0] rd_b
`else
   output logic [GW-1:0] rd_guess
`endif
);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_JUDGE = 3'd2, S_WIN = 3'd3, S_LOSE = 3'd4;

   logic [2:0]    r_st, w_nx;
   logic [GW-1:0] r_secret, r_guess;
   logic [IW-1:0] r_idx;
   logic [CW-1:0] r_acc_a, r_acc_b, r_a, r_b, w_a_fin, w_b_fin, w_bc;
   logic [AW:0]   r_tries, w_tries_nx;
   logic          r_rv, r_err, w_valid, w_last, w_eq, w_rd_ok;
   logic [3:0]    w_gd;
   logic [GW-1:0] r_hist [2**AW];
`ifdef GUESS_HIST_SCORE_EN
   logic [CW-1:0] r_ha [2**AW];
   logic [CW-1:0] r_hb [2**AW];
`endif

   // A guess is playable only if every digit is BCD and all digits are distinct.
   always_comb begin
      w_valid = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (guess[i*4 +: 4] > 4'd9) w_valid = 1'b0;
         for (int j = i + 1; j < DIGITS; j++)
            if (guess[i*4 +: 4] == guess[j*4 +: 4]) w_valid = 1'b0;
      end
   end

   always_comb begin
      w_gd = r_guess[{r_idx, 2'b00} +: 4];
      w_eq = w_gd == r_secret[{r_idx, 2'b00} +: 4];
      w_bc = '0;
      for (int j = 0; j < DIGITS; j++)
         if (j != int'(r_idx) && w_gd == r_secret[j*4 +: 4]) w_bc = w_bc + 1'b1;
      w_a_fin    = r_acc_a + CW'(w_eq);
      w_b_fin    = r_acc_b + w_bc;
      w_last     = r_idx == IW'(DIGITS - 1);
      w_tries_nx = r_tries + 1'b1;
   end

   always_ff @(posedge clk)
      if (rst) r_st <= S_IDLE;
      else     r_st <= w_nx;

   always_comb begin
      w_nx = r_st;
      if (start)
         w_nx = S_PLAY;
      else if (r_st == S_PLAY && submit && w_valid)
         w_nx = S_JUDGE;
      else if (r_st == S_JUDGE && w_last)
         w_nx = w_a_fin == CW'(DIGITS) ? S_WIN :
                w_tries_nx == (AW+1)'(MAX_TRIES) ? S_LOSE : S_PLAY;
   end

   always_comb begin
      busy  = r_st == S_JUDGE;
      state = r_st == S_IDLE ? 2'd0 : r_st == S_WIN ? 2'd2 : r_st == S_LOSE ? 2'd3 : 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_secret <= '0;
         r_guess  <= '0;
         r_idx    <= '0;
         r_acc_a  <= '0;
         r_acc_b  <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_tries  <= '0;
         r_rv     <= 1'b0;
         r_err    <= 1'b0;
         for (int k = 0; k < 2**AW; k++) begin
            r_hist[k] <= '0;
`ifdef GUESS_HIST_SCORE_EN
            r_ha[k] <= '0;
            r_hb[k] <= '0;
`endif
         end
      end else begin
         r_rv  <= 1'b0;
         r_err <= 1'b0;
         if (start) begin
            r_secret <= secret;
            r_tries  <= '0;
            r_a      <= '0;
            r_b      <= '0;
         end else if (r_st == S_PLAY && submit) begin
            if (w_valid) begin
               r_guess <= guess;
               r_acc_a <= '0;
               r_acc_b <= '0;
               r_idx   <= '0;
            end else begin
               r_rv  <= 1'b1;
               r_err <= 1'b1;
            end
         end else if (r_st == S_JUDGE) begin
            r_idx   <= r_idx + 1'b1;
            r_acc_a <= w_a_fin;
            r_acc_b <= w_b_fin;
            if (w_last) begin
               r_a     <= w_a_fin;
               r_b     <= w_b_fin;
               r_tries <= w_tries_nx;
               r_rv    <= 1'b1;
               r_hist[r_tries[AW-1:0]] <= r_guess;
`ifdef GUESS_HIST_SCORE_EN
               r_ha[r_tries[AW-1:0]] <= w_a_fin;
               r_hb[r_tries[AW-1:0]] <= w_b_fin;
`endif
            end
         end
      end
   end

   // Entries from a previous game stay in memory but are masked by the current try count.
   assign w_rd_ok      = {1'b0, rd_addr} < r_tries;
   assign rd_guess     = w_rd_ok ? r_hist[rd_addr] : '0;
`ifdef GUESS_HIST_SCORE_EN
   assign rd_a         = w_rd_ok ? r_ha[rd_addr] : '0;
   assign rd_b         = w_rd_ok ? r_hb[rd_addr] : '0;
`endif
   assign result_valid = r_rv;
   assign err          = r_err;
   assign a_cnt        = r_a;
   assign b_cnt        = r_b;
   assign tries        = r_tries;
endmodule

// File: tb/tb_guess_engine.sv
// tb_guess_engine: directed checks of guess_engine at DIGITS=4/MAX_TRIES=8 and DIGITS=6/MAX_TRIES=3.
module tb_guess_engine;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   logic        start, submit, busy, rv, err;
   logic [15:0] secret, guess, rd_guess;
   logic [2:0]  a_cnt, b_cnt, rd_addr, rd_a, rd_b;
   logic [3:0]  tries;
   logic [1:0]  state;

   logic        start6, submit6, busy6, rv6, err6;
   logic [23:0] secret6, guess6, rd_guess6;
   logic [2:0]  a6, b6, tries6, rd_a6, rd_b6;
   logic [1:0]  state6, rd_addr6;

   guess_engine #(.DIGITS(4), .MAX_TRIES(8), .AW(3)) u_d4 (
      .clk(clk), .rst(rst), .start(start), .secret(secret), .submit(submit), .guess(guess),
      .busy(busy), .result_valid(rv), .err(err), .a_cnt(a_cnt), .b_cnt(b_cnt), .tries(tries),
      .state(state), .rd_addr(rd_addr),
`ifdef GUESS_HIST_SCORE_EN
      .rd_a(rd_a), .rd_b(rd_b),
`endif
      .rd_guess(rd_guess));

   guess_engine #(.DIGITS(6), .MAX_TRIES(3), .AW(2)) u_d6 (
      .clk(clk), .rst(rst), .start(start6), .secret(secret6), .submit(submit6), .guess(guess6),
      .busy(busy6), .result_valid(rv6), .err(err6), .a_cnt(a6), .b_cnt(b6), .tries(tries6),
      .state(state6), .rd_addr(rd_addr6),
`ifdef GUESS_HIST_SCORE_EN
      .rd_a(rd_a6), .rd_b(rd_b6),
`endif
      .rd_guess(rd_guess6));

`ifndef GUESS_HIST_SCORE_EN
   assign rd_a = '0;
   assign rd_b = '0;
   assign rd_a6 = '0;
   assign rd_b6 = '0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_game(input logic [15:0] s);
      secret = s;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Returns cycles from the submit edge to result_valid, plus busy one cycle after submit.
   task automatic sub(input logic [15:0] g, output int lat, output logic b1);
      guess = g;
      submit = 1'b1;
      tick();
      submit = 1'b0;
      b1 = busy;
      lat = 1;
      while (!rv && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic watch(input int n, output int c);
      c = 0;
      repeat (n) begin
         tick();
         if (rv) c++;
      end
   endtask

   initial begin
      int lat, n;
      logic b1;
      start = 0; submit = 0; secret = 0; guess = 0; rd_addr = 0;
      start6 = 0; submit6 = 0; secret6 = 0; guess6 = 0; rd_addr6 = 0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_state", state, 0);
      chk("rst_tries", tries, 0);
      chk("rst_a", a_cnt, 0);
      chk("rst_b", b_cnt, 0);
      chk("rst_rv", rv, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd", rd_guess, 0);

      guess = 16'h1243; submit = 1'b1; tick(); submit = 1'b0;
      watch(6, n);
      chk("idle_submit_rv", n, 0);
      chk("idle_submit_state", state, 0);

      start_game(16'h1234);
      chk("start_state", state, 1);
      sub(16'h1243, lat, b1);
      chk("g1_lat", lat, 5);
      chk("g1_busy", b1, 1);
      chk("g1_err", err, 0);
      chk("g1_a", a_cnt, 2);
      chk("g1_b", b_cnt, 2);
      chk("g1_tries", tries, 1);
      chk("g1_state", state, 1);
      rd_addr = 0; #1;
      chk("g1_rd0", rd_guess, 16'h1243);
`ifdef GUESS_HIST_SCORE_EN
      chk("g1_rda", rd_a, 2);
      chk("g1_rdb", rd_b, 2);
`endif
      rd_addr = 1; #1;
      chk("g1_rd1", rd_guess, 0);

      sub(16'h1123, lat, b1);
      chk("dup_lat", lat, 1);
      chk("dup_err", err, 1);
      chk("dup_tries", tries, 1);
      chk("dup_a_hold", a_cnt, 2);
      chk("dup_rd1", rd_guess, 0);
      sub(16'h12A4, lat, b1);
      chk("bcd_lat", lat, 1);
      chk("bcd_err", err, 1);

      sub(16'h1234, lat, b1);
      chk("win_lat", lat, 5);
      chk("win_a", a_cnt, 4);
      chk("win_b", b_cnt, 0);
      chk("win_state", state, 2);
      chk("win_tries", tries, 2);
      guess = 16'h1243; submit = 1'b1; tick(); submit = 1'b0;
      watch(8, n);
      chk("win_submit_rv", n, 0);
      chk("win_a_hold", a_cnt, 4);

      start_game(16'h1234);
      chk("restart_a", a_cnt, 0);
      rd_addr = 0; #1;
      chk("restart_rd_hidden", rd_guess, 0);
      for (int i = 0; i < 8; i++) begin
         sub(16'h5678, lat, b1);
         chk("lose_lat", lat, 5);
         chk("lose_a", a_cnt, 0);
         if (i == 6) chk("lose_7_state", state, 1);
      end
      chk("lose_tries", tries, 8);
      chk("lose_state", state, 3);
      rd_addr = 7; #1;
      chk("lose_rd7", rd_guess, 16'h5678);
      guess = 16'h1234; submit = 1'b1; tick(); submit = 1'b0;
      watch(8, n);
      chk("lose_submit_rv", n, 0);

      start_game(16'h1234);
      for (int i = 0; i < 7; i++) sub(16'h5678, lat, b1);
      sub(16'h1234, lat, b1);
      chk("lastwin_tries", tries, 8);
      chk("lastwin_state", state, 2);

      start_game(16'h1234);
      guess = 16'h1243; submit = 1'b1; tick(); submit = 1'b0;
      tick();
      chk("judge_busy", busy, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_state", state, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_tries", tries, 0);
      chk("midrst_rv", rv, 0);
      watch(6, n);
      chk("midrst_no_rv", n, 0);

      start_game(16'h1234);
      secret = 16'h1234; guess = 16'h1243; start = 1'b1; submit = 1'b1;
      tick();
      start = 1'b0; submit = 1'b0;
      chk("ss_state", state, 1);
      chk("ss_tries", tries, 0);
      watch(8, n);
      chk("ss_no_rv", n, 0);

      secret6 = 24'h012345; start6 = 1'b1; tick(); start6 = 1'b0;
      guess6 = 24'h543210; submit6 = 1'b1; tick(); submit6 = 1'b0;
      lat = 1;
      while (!rv6 && lat < 20) begin
         tick();
         lat++;
      end
      chk("d6_lat", lat, 7);
      chk("d6_err", err6, 0);
      chk("d6_a", a6, 0);
      chk("d6_b", b6, 6);
      chk("d6_tries", tries6, 1);
      chk("d6_state", state6, 1);
      rd_addr6 = 2; #1;
      chk("d6_rd2", rd_guess6, 0);
      chk("d6_rda2", rd_a6, 0);
      chk("d6_rdb2", rd_b6, 0);
      rd_addr6 = 0; #1;
      chk("d6_rd0", rd_guess6, 24'h543210);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
